// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory and holds the core in reset until its checksum verifies
module imem_loader #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst_n
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] len_q, len_d, cnt_q, cnt_d, buf_q, buf_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]  sum_q, sum_d;
    logic [3:0]  strb_q, strb_d, wstrb_q, wstrb_d;
    logic        we_q, we_d, ready_q, busy_q, done_q, err_q, cpu_q;
    logic        acc, last;
    logic [1:0]  lane;
    logic [31:0] shifted, len_full, buf_new;
    logic [3:0]  strb_new;

    // The byte counter doubles as the header byte index and the payload byte index, so its low bits pick the lane
    assign acc      = s_valid && ready_q;
    assign lane     = cnt_q[1:0];
    assign last     = cnt_q == len_q - 32'd1;
    assign shifted  = 32'(s_data) << {lane, 3'b000};
    assign len_full = len_q | shifted;
    assign buf_new  = buf_q | shifted;
    assign strb_new = strb_q | (4'b0001 << lane);

    // Next-state: header assembly, payload packing with word commit, checksum verdict
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        buf_d   = buf_q;
        strb_d  = strb_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d = LEN;
                len_d   = '0;
                cnt_d   = '0;
                sum_d   = '0;
                buf_d   = '0;
                strb_d  = '0;
            end
            LEN: if (acc) begin
                len_d = len_full;
                cnt_d = cnt_q + 32'd1;
                if (lane == 2'd3) begin
                    cnt_d   = '0;
                    state_d = len_full > MEM_BYTES ? ERR : len_full == 32'd0 ? CSUM : DATA;
                end
            end
            DATA: if (acc) begin
                sum_d  = sum_q + s_data;
                cnt_d  = cnt_q + 32'd1;
                buf_d  = buf_new;
                strb_d = strb_new;
                if (lane == 2'd3 || last) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + {cnt_q[31:2], 2'b00};
                    wdata_d = buf_new;
                    wstrb_d = strb_new;
                    buf_d   = '0;
                    strb_d  = '0;
                end
                if (last) state_d = CSUM;
            end
            CSUM: if (acc) state_d = (sum_q + s_data) == 8'd0 ? DONE : ERR;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            buf_q   <= '0;
            strb_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cpu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            buf_q   <= buf_d;
            strb_q  <= strb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= state_d inside {LEN, DATA, CSUM};
            busy_q  <= state_d inside {LEN, DATA, CSUM};
            done_q  <= state_d == DONE;
            err_q   <= state_d == ERR;
            cpu_q   <= state_d == DONE;
        end
    end

    assign s_ready   = ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_rst_n = cpu_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks plus randomized images checked against a word-level image model
module tb_imem_loader;
    localparam int unsigned MEMB = 4096;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk, rst_n, start, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, mem_we, busy, done, err, cpu_rst_n;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int checks = 0, failures = 0, stalls = 0, gap_max = 0;
    logic [67:0] wq[$];

    imem_loader #(.MEM_BYTES(MEMB), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe seen away from the active edge
    always @(negedge clk) if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata, mem_wstrb});

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Expected writes: one per started group of four bytes, lanes past the end stay 0 and unstrobed
    function automatic void model(input logic [7:0] p[$], output logic [67:0] e[$]);
        logic [31:0] d;
        logic [3:0]  s;
        e = {};
        for (int w = 0; w * 4 < p.size(); w++) begin
            d = '0;
            s = '0;
            for (int k = 0; k < 4; k++)
                if (w * 4 + k < p.size()) begin
                    d[8*k +: 8] = p[w*4+k];
                    s[k] = 1'b1;
                end
            e.push_back({BASE + 32'(w * 4), d, s});
        end
    endfunction

    function automatic logic [7:0] good_csum(input logic [7:0] p[$]);
        int s = 0;
        foreach (p[i]) s += int'(p[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic send(input logic [7:0] b);
        int n = 0;
        if (gap_max > 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (s_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout s_ready=%b required=1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input logic [31:0] len, input logic [7:0] p[$], input logic [7:0] c);
        pulse_start();
        for (int k = 0; k < 4; k++) send(len[8*k +: 8]);
        foreach (p[i]) send(p[i]);
        send(c);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, mem_we, busy, done, err, cpu_rst_n, mem_addr, mem_wdata, mem_wstrb} !== 74'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {s_ready, mem_we, busy, done, err, cpu_rst_n, mem_addr, mem_wdata, mem_wstrb});
        end
        rst_n = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h55;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if ({s_ready, busy, done, err, cpu_rst_n} !== 5'b0 || wq.size() != 0) begin
            failures++;
            $display("FAIL idle_hold got=%b writes=%0d required=00000 writes=0", {s_ready, busy, done, err, cpu_rst_n}, wq.size());
        end
    endtask

    task automatic test_nominal();
        logic [7:0] hdr[$] = '{8'h08, 8'h00, 8'h00, 8'h00};
        logic [7:0] p[$] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        wq = {};
        gap_max = 0;
        stalls = 0;
        pulse_start();
        checks++;
        if ({busy, s_ready, done} !== 3'b110) begin
            failures++;
            $display("FAIL nominal_len_state got=%b required=110", {busy, s_ready, done});
        end
        foreach (hdr[i]) send(hdr[i]);
        for (int i = 0; i < 4; i++) send(p[i]);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, BASE, 32'h0010_0513, 4'hF}) begin
            failures++;
            $display("FAIL nominal_word0 got=%h required=%h", {mem_we, mem_addr, mem_wdata, mem_wstrb}, {1'b1, BASE, 32'h0010_0513, 4'hF});
        end
        send(p[4]);
        checks++;
        if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL nominal_we_pulse got=%b required=0", mem_we);
        end
        for (int i = 5; i < 8; i++) send(p[i]);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, BASE + 32'd4, 32'h0020_0593, 4'hF}) begin
            failures++;
            $display("FAIL nominal_word1 got=%h required=%h", {mem_we, mem_addr, mem_wdata, mem_wstrb}, {1'b1, BASE + 32'd4, 32'h0020_0593, 4'hF});
        end
        send(8'h20);
        checks++;
        if ({done, cpu_rst_n, err, busy, s_ready} !== 5'b11000) begin
            failures++;
            $display("FAIL nominal_done got=%b required=11000", {done, cpu_rst_n, err, busy, s_ready});
        end
        @(negedge clk);
        checks++;
        if (wq.size() != 2 || stalls != 0) begin
            failures++;
            $display("FAIL nominal_count writes=%0d stalls=%0d required writes=2 stalls=0", wq.size(), stalls);
        end
    endtask

    task automatic test_partial();
        logic [7:0] p[$] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        wq = {};
        load(32'd5, p, good_csum(p));
        checks++;
        if (wq.size() != 2 || wq[0] !== {BASE, 32'hDDCC_BBAA, 4'hF} || wq[1] !== {BASE + 32'd4, 32'h0000_00EE, 4'b0001}) begin
            failures++;
            $display("FAIL partial_words writes=%0d first=%h last=%h required=%h,%h", wq.size(),
                     wq.size() > 0 ? wq[0] : 68'd0, wq.size() > 1 ? wq[1] : 68'd0,
                     {BASE, 32'hDDCC_BBAA, 4'hF}, {BASE + 32'd4, 32'h0000_00EE, 4'b0001});
        end
        checks++;
        if ({done, cpu_rst_n, err} !== 3'b110) begin
            failures++;
            $display("FAIL partial_done got=%b required=110", {done, cpu_rst_n, err});
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] p[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
        wq = {};
        load(32'd4, p, 8'h00);
        checks++;
        if (wq.size() != 1 || wq[0] !== {BASE, 32'h0403_0201, 4'hF}) begin
            failures++;
            $display("FAIL badcsum_write writes=%0d got=%h required=%h", wq.size(), wq.size() > 0 ? wq[0] : 68'd0, {BASE, 32'h0403_0201, 4'hF});
        end
        checks++;
        if ({err, done, cpu_rst_n, busy, s_ready} !== 5'b10000) begin
            failures++;
            $display("FAIL badcsum_err got=%b required=10000", {err, done, cpu_rst_n, busy, s_ready});
        end
    endtask

    task automatic test_oversize();
        logic [31:0] lens[2] = '{32'h0000_1004, MEMB + 1};
        foreach (lens[j]) begin
            wq = {};
            pulse_start();
            for (int k = 0; k < 4; k++) send(lens[j][8*k +: 8]);
            checks++;
            if ({err, s_ready, busy, done, cpu_rst_n} !== 5'b10000) begin
                failures++;
                $display("FAIL oversize_err len=%h got=%b required=10000", lens[j], {err, s_ready, busy, done, cpu_rst_n});
            end
            s_valid = 1'b1;
            repeat (4) @(negedge clk);
            s_valid = 1'b0;
            checks++;
            if (wq.size() != 0) begin
                failures++;
                $display("FAIL oversize_nowrite len=%h writes=%0d required=0", lens[j], wq.size());
            end
        end
    endtask

    task automatic test_zero_reload();
        logic [7:0] none[$];
        logic [7:0] p[$];
        logic [67:0] e[$];
        wq = {};
        pulse_start();
        for (int k = 0; k < 4; k++) send(8'h00);
        checks++;
        if ({busy, s_ready, done, mem_we} !== 4'b1100) begin
            failures++;
            $display("FAIL zero_csum_state got=%b required=1100", {busy, s_ready, done, mem_we});
        end
        send(8'h00);
        @(negedge clk);
        checks++;
        if ({done, cpu_rst_n, err} !== 3'b110 || wq.size() != 0) begin
            failures++;
            $display("FAIL zero_done got=%b writes=%0d required=110 writes=0", {done, cpu_rst_n, err}, wq.size());
        end
        pulse_start();
        checks++;
        if ({cpu_rst_n, done, busy, s_ready} !== 4'b0011) begin
            failures++;
            $display("FAIL reload_start got=%b required=0011", {cpu_rst_n, done, busy, s_ready});
        end
        for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
        wq = {};
        for (int k = 0; k < 4; k++) send(k == 0 ? 8'd8 : 8'd0);
        foreach (p[i]) send(p[i]);
        send(good_csum(p));
        repeat (2) @(negedge clk);
        model(p, e);
        checks++;
        if (wq.size() != e.size() || wq[0] !== e[0] || wq[1] !== e[1] || {done, cpu_rst_n} !== 2'b11) begin
            failures++;
            $display("FAIL reload_image writes=%0d flags=%b required writes=%0d flags=11", wq.size(), {done, cpu_rst_n}, e.size());
        end
        none = {};
    endtask

    task automatic test_reset_mid();
        logic [7:0] p[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [67:0] e[$];
        wq = {};
        pulse_start();
        for (int k = 0; k < 4; k++) send(k == 0 ? 8'd8 : 8'd0);
        for (int i = 0; i < 3; i++) send(p[i]);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, mem_we, busy, done, err, cpu_rst_n, mem_addr, mem_wdata, mem_wstrb} !== 74'd0) begin
            failures++;
            $display("FAIL midreset_async got=%h required=0", {s_ready, mem_we, busy, done, err, cpu_rst_n, mem_addr, mem_wdata, mem_wstrb});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'($urandom);
            s_data = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (wq.size() != 0 || {s_ready, busy, done, err} !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_idle writes=%0d flags=%b required writes=0 flags=0000", wq.size(), {s_ready, busy, done, err});
        end
        load(32'd5, p, good_csum(p));
        model(p, e);
        checks++;
        if (wq.size() != 2 || wq[0] !== e[0] || wq[1] !== e[1] || done !== 1'b1) begin
            failures++;
            $display("FAIL midreset_restart writes=%0d done=%b required writes=2 done=1", wq.size(), done);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [7:0] p[$];
            logic [67:0] e[$];
            int len;
            bit bad;
            len = (it == 24) ? int'(MEMB) : int'($urandom_range(0, 40));
            bad = (it != 24) && ($urandom_range(0, 3) == 0);
            gap_max = (it == 24) ? 0 : int'($urandom_range(0, 2));
            p = {};
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            model(p, e);
            wq = {};
            stalls = 0;
            load(32'(len), p, bad ? good_csum(p) + 8'($urandom_range(1, 255)) : good_csum(p));
            checks++;
            if (wq.size() != e.size()) begin
                failures++;
                $display("FAIL random_count it=%0d writes=%0d required=%0d", it, wq.size(), e.size());
            end
            foreach (e[i]) begin
                checks++;
                if (i >= wq.size() || wq[i] !== e[i]) begin
                    failures++;
                    $display("FAIL random_word it=%0d idx=%0d got=%h required=%h", it, i, i < wq.size() ? wq[i] : 68'd0, e[i]);
                end
            end
            checks++;
            if ({done, cpu_rst_n, err, busy} !== {!bad, !bad, bad, 1'b0} || stalls != 0) begin
                failures++;
                $display("FAIL random_status it=%0d got=%b stalls=%0d required=%b stalls=0", it, {done, cpu_rst_n, err, busy}, stalls, {!bad, !bad, bad, 1'b0});
            end
        end
        gap_max = 0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_partial();
        test_bad_csum();
        test_oversize();
        test_zero_reload();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
